wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo2.sv | 61 ++++++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Sized to a 32-entry, 32-bit register file.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer for long-latency writebacks. Slot 0 is always the head.
// Both slots are visible so the issue stage can match pending destinations.
module wb_fifo2
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t wr_req,
  output logic    full,
  output logic    empty,
  output wb_req_t head,
  output wb_req_t ent0,
  output wb_req_t ent1,
  output logic    ent0_vld,
  output logic    ent1_vld
);

  logic [1:0] cnt_q, cnt_d;
  wb_req_t    slot0_q, slot0_d;
  wb_req_t    slot1_q, slot1_d;
  logic       push_ok, pop_ok;

  always_comb begin
    push_ok = push && (cnt_q != 2'd2);
    pop_ok  = pop && (cnt_q != 2'd0);
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop_ok) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_d - 2'd1;
    end
    if (push_ok) begin
      // the new entry lands right behind whatever survives this cycle's pop
      if (cnt_d == 2'd0) slot0_d = wr_req;
      else               slot1_d = wr_req;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign head     = slot0_q;
  assign ent0     = slot0_q;
  assign ent1     = slot1_q;
  assign ent0_vld = (cnt_q != 2'd0);
  assign ent1_vld = (cnt_q == 2'd2);

endmodule

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter: port A has priority, buffered port B is forced
// through after STARVE_LIMIT lost cycles. Define WB_ARB_FORWARD_EN to build the forwarding mux.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_DW-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_DW-1:0] b_data,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [REG_DW-1:0] wd3,
  input  logic [REG_AW-1:0] rq_addr,
  output logic              rq_pend,
  output logic              fwd_hit,
  output logic [REG_DW-1:0] fwd_data
);

  localparam logic [3:0] STARVE_TC = 4'(STARVE_LIMIT);

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       ent0_vld, ent1_vld;
  wb_req_t    fifo_head, ent0, ent1, b_req;
  logic       forced, a_grant, b_grant;
  logic       match0, match1;
  logic [3:0] starve_q, starve_d;
  logic       we3_q, we3_d;
  wb_req_t    out_q, out_d;

  assign b_req = '{addr: b_addr, data: b_data};

  wb_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wr_req   (b_req),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .ent0     (ent0),
    .ent1     (ent1),
    .ent0_vld (ent0_vld),
    .ent1_vld (ent1_vld)
  );

  always_comb begin
    forced    = !fifo_empty && (starve_q == STARVE_TC);
    a_ready   = !rst && !forced;
    b_ready   = !rst && !fifo_full;
    // A writes to r0 are swallowed, which leaves the slot free for the B head
    a_grant   = a_valid && a_ready && (a_addr != '0);
    b_grant   = !rst && !fifo_empty && !a_grant;
    fifo_push = b_valid && b_ready && (b_addr != '0);
    fifo_pop  = b_grant;
    starve_d  = (fifo_empty || b_grant) ? 4'd0 : starve_q + 4'd1;
    we3_d     = a_grant || b_grant;
    out_d     = out_q;
    if (a_grant)      out_d = '{addr: a_addr, data: a_data};
    else if (b_grant) out_d = fifo_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      we3_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      starve_q <= starve_d;
      we3_q    <= we3_d;
      out_q    <= out_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = out_q.addr;
  assign wd3 = out_q.data;

  always_comb begin
    match0  = ent0_vld && (ent0.addr == rq_addr);
    match1  = ent1_vld && (ent1.addr == rq_addr);
    rq_pend = !rst && (rq_addr != '0) && (match0 || match1);
  end

`ifdef WB_ARB_FORWARD_EN
  always_comb begin
    fwd_hit  = rq_pend;
    fwd_data = '0;
    if (rq_pend) fwd_data = match1 ? ent1.data : ent0.data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ent0.data, ent1.data};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run checked against a
// queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, rq_addr, a3;
  logic [31:0] a_data, b_data, wd3, fwd_data;
  logic        we3, rq_pend, fwd_hit;

  int n_checks = 0;
  int n_pass   = 0;

  wb_req_t     mq[$];
  int          m_starve = 0;
  logic        m_we3 = 1'b0;
  logic [4:0]  m_a3 = 5'd0;
  logic [31:0] m_wd3 = 32'd0;
  logic        exp_a_ready, exp_b_ready, exp_rq_pend, exp_fwd_hit;
  logic [31:0] exp_fwd_data;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .a3(a3), .wd3(wd3),
    .rq_addr(rq_addr), .rq_pend(rq_pend), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Applies inputs for one cycle (called just after a falling edge) and derives the
  // expected combinational outputs from the model state.
  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic [4:0] rq);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; rq_addr = rq;
    exp_b_ready  = !r && (mq.size() < 2);
    exp_a_ready  = !r && !(mq.size() > 0 && m_starve == LIMIT);
    exp_rq_pend  = 1'b0;
    exp_fwd_data = 32'd0;
    if (!r && rq != 5'd0)
      foreach (mq[i])
        if (mq[i].addr == rq) begin
          exp_rq_pend  = 1'b1;
          exp_fwd_data = mq[i].data;
        end
`ifdef WB_ARB_FORWARD_EN
    exp_fwd_hit = exp_rq_pend;
`else
    exp_fwd_hit  = 1'b0;
    exp_fwd_data = 32'd0;
`endif
    #1;
  endtask

  // Advances the model by one clock using the inputs applied by drive, then steps the DUT.
  task automatic tick();
    int      sz;
    logic    took_b;
    wb_req_t w;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_we3 = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0;
    end else begin
      sz = mq.size();
      took_b = 1'b0;
      m_we3 = 1'b0;
      if (a_valid && exp_a_ready && a_addr != 5'd0) begin
        m_we3 = 1'b1; m_a3 = a_addr; m_wd3 = a_data;
      end else if (sz > 0) begin
        w = mq.pop_front();
        m_we3 = 1'b1; m_a3 = w.addr; m_wd3 = w.data;
        took_b = 1'b1;
      end
      if (sz == 0 || took_b) m_starve = 0;
      else                   m_starve = m_starve + 1;
      if (b_valid && exp_b_ready && b_addr != 5'd0) begin
        w.addr = b_addr; w.data = b_data;
        mq.push_back(w);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
    tick(); tick();
    drive(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd4);
    n_checks++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got=%b exp=0", a_ready); else n_pass++;
    n_checks++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready got=%b exp=0", b_ready); else n_pass++;
    n_checks++; if (we3 !== 1'b0) $display("FAIL rst_we3 got=%b exp=0", we3); else n_pass++;
    n_checks++; if (a3 !== 5'd0) $display("FAIL rst_a3 got=%0d exp=0", a3); else n_pass++;
    n_checks++; if (wd3 !== 32'd0) $display("FAIL rst_wd3 got=%h exp=0", wd3); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL rst_rq_pend got=%b exp=0", rq_pend); else n_pass++;
    n_checks++; if (fwd_hit !== 1'b0) $display("FAIL rst_fwd_hit got=%b exp=0", fwd_hit); else n_pass++;
    n_checks++; if (fwd_data !== 32'd0) $display("FAIL rst_fwd_data got=%h exp=0", fwd_data); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (a_ready !== 1'b1) $display("FAIL post_rst_a_ready got=%b exp=1", a_ready); else n_pass++;
    n_checks++; if (b_ready !== 1'b1) $display("FAIL post_rst_b_ready got=%b exp=1", b_ready); else n_pass++;
    n_checks++; if (we3 !== 1'b0) $display("FAIL post_rst_we3 got=%b exp=0", we3); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (a_ready !== 1'b1) $display("FAIL b2b_a_ready got=%b exp=1", a_ready); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (we3 !== 1'b1) $display("FAIL b2b_we3_first got=%b exp=1", we3); else n_pass++;
    n_checks++; if (a3 !== 5'd5) $display("FAIL b2b_a3_first got=%0d exp=5", a3); else n_pass++;
    n_checks++; if (wd3 !== 32'h11) $display("FAIL b2b_wd3_first got=%h exp=11", wd3); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (we3 !== 1'b1) $display("FAIL b2b_we3_second got=%b exp=1", we3); else n_pass++;
    n_checks++; if (a3 !== 5'd6) $display("FAIL b2b_a3_second got=%0d exp=6", a3); else n_pass++;
    n_checks++; if (wd3 !== 32'h22) $display("FAIL b2b_wd3_second got=%h exp=22", wd3); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (we3 !== 1'b0) $display("FAIL b2b_we3_idle got=%b exp=0", we3); else n_pass++;
    n_checks++; if (a3 !== 5'd6) $display("FAIL b2b_a3_hold got=%0d exp=6", a3); else n_pass++;
    n_checks++; if (wd3 !== 32'h22) $display("FAIL b2b_wd3_hold got=%h exp=22", wd3); else n_pass++;
    tick();
  endtask

  task automatic test_b_buffer();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD, 5'd7);
    n_checks++; if (b_ready !== 1'b1) $display("FAIL bbuf_b_ready got=%b exp=1", b_ready); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL bbuf_rq_pend_pre got=%b exp=0", rq_pend); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
    n_checks++; if (rq_pend !== 1'b1) $display("FAIL bbuf_rq_pend got=%b exp=1", rq_pend); else n_pass++;
    n_checks++; if (fwd_hit !== exp_fwd_hit) $display("FAIL bbuf_fwd_hit got=%b exp=%b", fwd_hit, exp_fwd_hit); else n_pass++;
    n_checks++; if (fwd_data !== exp_fwd_data) $display("FAIL bbuf_fwd_data got=%h exp=%h", fwd_data, exp_fwd_data); else n_pass++;
    n_checks++; if (we3 !== 1'b0) $display("FAIL bbuf_we3_early got=%b exp=0", we3); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
    n_checks++; if (we3 !== 1'b1) $display("FAIL bbuf_we3 got=%b exp=1", we3); else n_pass++;
    n_checks++; if (a3 !== 5'd7) $display("FAIL bbuf_a3 got=%0d exp=7", a3); else n_pass++;
    n_checks++; if (wd3 !== 32'hDEAD) $display("FAIL bbuf_wd3 got=%h exp=dead", wd3); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL bbuf_rq_pend_post got=%b exp=0", rq_pend); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    logic [4:0] seq[$];
    logic [4:0] exp_seq[10];
    int k = 1, cyc = 0, low_cyc = -1, low_cnt = 0;
    logic b_sent = 1'b0;
    exp_seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd6, 5'd7, 5'd8, 5'd9};
    while (k <= 9 && cyc < 40) begin
      drive(1'b0, 1'b1, k[4:0], 32'h100 + 32'(k), !b_sent, 5'd8, 32'hBEEF, 5'd0);
      if (!b_sent && b_ready === 1'b1) b_sent = 1'b1;
      if (a_ready === 1'b0) begin
        low_cnt++;
        if (low_cyc < 0) low_cyc = cyc;
      end
      if (a_ready === 1'b1) k++;
      tick();
      cyc++;
      if (we3 === 1'b1) seq.push_back(a3);
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    if (we3 === 1'b1) seq.push_back(a3);
    n_checks++; if (k != 10) $display("FAIL starve_timeout got_k=%0d exp=10", k); else n_pass++;
    n_checks++; if (low_cyc != 5) $display("FAIL starve_low_cycle got=%0d exp=5", low_cyc); else n_pass++;
    n_checks++; if (low_cnt != 1) $display("FAIL starve_low_count got=%0d exp=1", low_cnt); else n_pass++;
    n_checks++; if (seq.size() != 10) $display("FAIL starve_nwrites got=%0d exp=10", seq.size()); else n_pass++;
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== exp_seq[i]) $display("FAIL starve_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_fifo_full();
    logic [4:0] seq[$];
    logic [4:0] exp_seq[3];
    int bi = 0, cyc = 0, first_full = -1;
    exp_seq = '{5'd2, 5'd3, 5'd4};
    while (seq.size() < 3 && cyc < 60) begin
      drive(1'b0, 1'b1, 5'(10 + cyc % 16), 32'(cyc), bi < 3, 5'(2 + bi), 32'hB0 + 32'(bi), 5'd0);
      if (b_ready === 1'b0 && first_full < 0) first_full = cyc;
      if (bi < 3 && b_ready === 1'b1) bi++;
      tick();
      cyc++;
      if (we3 === 1'b1 && a3 >= 5'd2 && a3 <= 5'd4) seq.push_back(a3);
    end
    n_checks++; if (seq.size() != 3) $display("FAIL full_nwrites got=%0d exp=3 (cycle budget)", seq.size()); else n_pass++;
    n_checks++; if (first_full != 2) $display("FAIL full_b_ready_low got_cycle=%0d exp=2", first_full); else n_pass++;
    for (int i = 0; i < 3 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== exp_seq[i]) $display("FAIL full_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
  endtask

  task automatic test_r0();
    drive(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0);
    n_checks++; if (a_ready !== 1'b1) $display("FAIL r0_a_ready got=%b exp=1", a_ready); else n_pass++;
    n_checks++; if (b_ready !== 1'b1) $display("FAIL r0_b_ready got=%b exp=1", b_ready); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL r0_rq_pend got=%b exp=0", rq_pend); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (we3 !== 1'b0) $display("FAIL r0_we3_a got=%b exp=0", we3); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL r0_rq_pend_after got=%b exp=0", rq_pend); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    n_checks++; if (we3 !== 1'b0) $display("FAIL r0_we3_b got=%b exp=0", we3); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 5'd20, 32'hA20, 1'b1, 5'd12, 32'hC12, 5'd12);
    tick();
    drive(1'b0, 1'b1, 5'd21, 32'hA21, 1'b1, 5'd13, 32'hC13, 5'd12);
    tick();
    drive(1'b0, 1'b1, 5'd22, 32'hA22, 1'b0, 5'd0, 32'd0, 5'd13);
    n_checks++; if (b_ready !== 1'b0) $display("FAIL rmid_full got=%b exp=0", b_ready); else n_pass++;
    n_checks++; if (rq_pend !== 1'b1) $display("FAIL rmid_pend_pre got=%b exp=1", rq_pend); else n_pass++;
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12);
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL rmid_pend_in_rst got=%b exp=0", rq_pend); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12);
    n_checks++; if (we3 !== 1'b0) $display("FAIL rmid_we3_edge got=%b exp=0", we3); else n_pass++;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL rmid_a_ready got=%b exp=1", a_ready); else n_pass++;
    n_checks++; if (b_ready !== 1'b1) $display("FAIL rmid_b_ready got=%b exp=1", b_ready); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL rmid_rq_pend got=%b exp=0", rq_pend); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13);
    n_checks++; if (we3 !== 1'b0) $display("FAIL rmid_we3_after got=%b exp=0", we3); else n_pass++;
    n_checks++; if (rq_pend !== 1'b0) $display("FAIL rmid_rq_pend13 got=%b exp=0", rq_pend); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic r, av, bv;
    logic [4:0] aa, ba, rq;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      av = ($urandom_range(0, 3) != 0);
      aa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bv = ($urandom_range(0, 1) == 1);
      ba = 5'($urandom_range(0, 7));
      rq = 5'($urandom_range(0, 7));
      drive(r, av, aa, $urandom, bv, ba, $urandom, rq);
      n_checks++; if (a_ready !== exp_a_ready) $display("FAIL rnd_a_ready cyc=%0d got=%b exp=%b", i, a_ready, exp_a_ready); else n_pass++;
      n_checks++; if (b_ready !== exp_b_ready) $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", i, b_ready, exp_b_ready); else n_pass++;
      n_checks++; if (rq_pend !== exp_rq_pend) $display("FAIL rnd_rq_pend cyc=%0d got=%b exp=%b", i, rq_pend, exp_rq_pend); else n_pass++;
      n_checks++; if (fwd_hit !== exp_fwd_hit) $display("FAIL rnd_fwd_hit cyc=%0d got=%b exp=%b", i, fwd_hit, exp_fwd_hit); else n_pass++;
      n_checks++; if (fwd_data !== exp_fwd_data) $display("FAIL rnd_fwd_data cyc=%0d got=%h exp=%h", i, fwd_data, exp_fwd_data); else n_pass++;
      tick();
      n_checks++; if (we3 !== m_we3) $display("FAIL rnd_we3 cyc=%0d got=%b exp=%b", i, we3, m_we3); else n_pass++;
      n_checks++; if (a3 !== m_a3) $display("FAIL rnd_a3 cyc=%0d got=%0d exp=%0d", i, a3, m_a3); else n_pass++;
      n_checks++; if (wd3 !== m_wd3) $display("FAIL rnd_wd3 cyc=%0d got=%h exp=%h", i, wd3, m_wd3); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_b_buffer();
    test_starve();
    test_fifo_full();
    test_r0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
